serial_operand_loader: RTL and testbench
========================================

Name: serial_operand_loader

Overview:
- Upstream feeder for the serial adder stage.
- Accepts two WIDTH-bit parallel operands through a valid/ready handshake.
- Pulses the adder's reset to clear its carry, then streams both operands LSB-first, one bit per clock, with framing.
- Signals completion so the next operand pair can be loaded.

Parameters:
WIDTH, 4, operand width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
load_valid  input  1  producer has an operand pair on op_a/op_b
load_ready  output  1  block can accept an operand pair (high only in IDLE)
op_a  input  WIDTH  operand A, sampled on handshake
op_b  input  WIDTH  operand B, sampled on handshake
adder_reset  output  1  one-cycle clear pulse to the serial adder's reset input
a_bit  output  1  serial bit of operand A to the adder's a input
b_bit  output  1  serial bit of operand B to the adder's b input
bit_valid  output  1  a_bit/b_bit carry a live operand bit this cycle
last_bit  output  1  current bit is bit WIDTH-1
done  output  1  one-cycle pulse after the last bit

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - While reset is high, all outputs are 0, including load_ready.
  - Shift registers and bit counter are cleared; state goes to IDLE.
  - load_ready rises in the first cycle after reset deasserts.
- Handshake: a transfer occurs on a rising edge where load_valid && load_ready.
  - At that edge, op_a and op_b are captured into shift registers sr_a and sr_b, and cnt is set to 0.
  - load_valid outside IDLE is ignored. No queuing.
- States (registered FSM; outputs decoded from the state register):
  - IDLE: load_ready=1. All other outputs 0. On handshake, go to CLEAR.
  - CLEAR: adder_reset=1. a_bit=b_bit=0, bit_valid=0. Unconditionally go to SHIFT.
  - SHIFT:
    - a_bit=sr_a[0], b_bit=sr_b[0], bit_valid=1.
    - last_bit=1 when cnt==WIDTH-1.
    - Each edge shifts sr_a and sr_b right (zero fill) and increments cnt.
    - After the cycle with cnt==WIDTH-1, go to DONE.
  - DONE: done=1 for one cycle. Go to IDLE.
- Latency, with the handshake at edge t:
  - adder_reset is high in cycle t+1.
  - bit 0 appears in cycle t+2.
  - bit WIDTH-1 appears in cycle t+1+WIDTH.
  - done is high in cycle t+2+WIDTH.
  - load_ready returns in cycle t+3+WIDTH.
  - Minimum operand period is WIDTH+3 cycles.
- Counter: width $clog2(WIDTH), cleared on handshake; it never wraps inside an operation.
- Outside SHIFT, a_bit and b_bit are held at 0, so the adder sees 0+0 and its carry is not disturbed.
- Reset mid-operation: the frame is abandoned and no done is issued. The next frame begins with a fresh CLEAR pulse.
- Reset asserted in the same cycle as load_valid: reset wins and nothing is captured.

Optional Feature:
SERIAL_OPERAND_LOADER_CAPTURE_EN
- Defined:
  - Adds input sum_bit (1 bit, from the adder's sum output) and output result (WIDTH bits).
  - The adder's sum is registered, one cycle behind its inputs. sum_bit is therefore sampled in the cycle after each bit_valid cycle: SHIFT cycles 1..WIDTH-1 plus the DONE cycle.
  - Each sampled bit is shifted into result from the MSB side.
  - result is stable and correct (sum modulo 2^WIDTH; final carry dropped) from the cycle done is high until the next handshake.
  - Reset clears result to 0.
- Undefined: the sum_bit and result ports do not exist, and there is no capture logic.

Decomposition:
- Shared package serial_pkg holds:
  - FSM state encodings ST_IDLE, ST_CLEAR, ST_SHIFT, ST_DONE (2-bit localparams).
  - The default width constant SERIAL_WIDTH=4.
- Sub-module piso_shift_reg (parameter WIDTH; ports clk, reset, load, shift, d, q_lsb), instantiated twice, for A and B.
- The FSM and counter stay in the top.

Test Plan:
1. Reset held 3 cycles, then released -> all outputs 0 during reset; load_ready=1 in the first cycle after release.
2. WIDTH=4, op_a=4'b0101, op_b=4'b0011, load_valid pulsed -> adder_reset high in cycle t+1. a_bit sequence 1,0,1,0 and b_bit sequence 1,1,0,0 in cycles t+2..t+5. last_bit high in t+5. done high in t+6.
3. With CAPTURE_EN and a serial-adder model looped back, 5+3 -> result=4'b1000. Also 4'hF+4'h1 -> result=4'h0 (carry dropped).
4. load_valid held high with changing operands -> handshakes spaced exactly 7 cycles apart. Operands presented during busy cycles are not captured.
5. Reset asserted in the second SHIFT cycle -> next cycle all outputs 0 and no done pulse. A new load produces a full CLEAR plus 4-bit frame.
6. Reset and load_valid both high on the same edge -> no capture; load_ready=1 the following cycle.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared constants for the serial operand loader: FSM encodings and default operand width.
package serial_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int SERIAL_WIDTH = 4;
endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register; emits LSB first, zero-filling from the top.
module piso_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q_lsb
);
    logic [WIDTH-1:0] r_sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr <= '0;
        end else if (load) begin
            r_sr <= d;
        end else if (shift) begin
            r_sr <= {1'b0, r_sr[WIDTH-1:1]};
        end
    end

    assign q_lsb = r_sr[0];
endmodule

// File: rtl/serial_operand_loader.sv
// Loads an operand pair, pulses the serial adder's clear, then streams both operands LSB-first.
// Optional sum capture into a parallel result is enabled by SERIAL_OPERAND_LOADER_CAPTURE_EN.
module serial_operand_loader
    import serial_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             adder_reset,
    output logic             a_bit,
    output logic             b_bit,
    output logic             bit_valid,
    output logic             last_bit,
    output logic             done
`ifdef SERIAL_OPERAND_LOADER_CAPTURE_EN
    ,
    input  logic             sum_bit,
    output logic [WIDTH-1:0] result
`endif
);
    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [CW-1:0]    r_cnt;
    logic             w_hs;
    logic             w_shift;
    logic             w_last;
    logic [WIDTH-1:0] w_op [2];
    logic [1:0]       w_q;

    assign w_shift = (r_state == ST_SHIFT);
    assign w_last  = w_shift && (r_cnt == LAST_CNT);
    assign w_hs    = load_valid && load_ready;

    assign w_op[0] = op_a;
    assign w_op[1] = op_b;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_piso
            piso_shift_reg #(.WIDTH(WIDTH)) u_piso (
                .clk   (clk),
                .reset (reset),
                .load  (w_hs),
                .shift (w_shift),
                .d     (w_op[gi]),
                .q_lsb (w_q[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Counter holds at WIDTH-1 on the final bit so it never wraps mid-frame.
    always_ff @(posedge clk) begin
        if (reset || w_hs) begin
            r_cnt <= '0;
        end else if (w_shift && !w_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (load_valid) w_state_next = ST_CLEAR;
            ST_CLEAR: w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_last) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Reset forces every output low immediately, not just after the next edge.
    always_comb begin
        load_ready  = 1'b0;
        adder_reset = 1'b0;
        a_bit       = 1'b0;
        b_bit       = 1'b0;
        bit_valid   = 1'b0;
        last_bit    = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE:  load_ready  = 1'b1;
            ST_CLEAR: adder_reset = 1'b1;
            ST_SHIFT: begin
                a_bit     = w_q[0];
                b_bit     = w_q[1];
                bit_valid = 1'b1;
                last_bit  = w_last;
            end
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
        if (reset) begin
            load_ready  = 1'b0;
            adder_reset = 1'b0;
            a_bit       = 1'b0;
            b_bit       = 1'b0;
            bit_valid   = 1'b0;
            last_bit    = 1'b0;
            done        = 1'b0;
        end
    end

`ifdef SERIAL_OPERAND_LOADER_CAPTURE_EN
    logic             r_sample;
    logic [WIDTH-1:0] r_result;

    // The adder's sum lags its inputs by one cycle, so sample one cycle after each live bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample <= 1'b0;
            r_result <= '0;
        end else begin
            r_sample <= w_shift;
            if (r_sample) begin
                r_result <= {sum_bit, r_result[WIDTH-1:1]};
            end
        end
    end

    // During DONE the final sum bit is merged combinationally so result is valid alongside done.
    always_comb begin
        result = r_result;
        if (r_state == ST_DONE) begin
            result = {sum_bit, r_result[WIDTH-1:1]};
        end
        if (reset) begin
            result = '0;
        end
    end
`endif
endmodule

// File: tb/tb_serial_operand_loader.sv
// Scoreboard bench: the driver queues expected frames, a negedge monitor checks every cycle.
module tb_serial_operand_loader;
    localparam int W = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
    } frame_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load_valid = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         load_ready, adder_reset, a_bit, b_bit, bit_valid, last_bit, done;
`ifdef SERIAL_OPERAND_LOADER_CAPTURE_EN
    logic         sum_bit;
    logic [W-1:0] result;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pushes = 0;
    int aborted = 0;
    int frames_done = 0;
    frame_t exp_q [$];

    logic [W-1:0] tab_a [8] = '{4'h5, 4'hF, 4'hA, 4'h9, 4'h7, 4'hC, 4'hE, 4'h3};
    logic [W-1:0] tab_b [8] = '{4'h3, 4'h1, 4'h6, 4'h9, 4'h8, 4'h5, 4'hE, 4'h4};
    logic [W-1:0] tab_r [8] = '{4'h8, 4'h0, 4'h0, 4'h2, 4'hF, 4'h1, 4'hC, 4'h7};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_operand_loader #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .adder_reset (adder_reset),
        .a_bit       (a_bit),
        .b_bit       (b_bit),
        .bit_valid   (bit_valid),
        .last_bit    (last_bit),
        .done        (done)
`ifdef SERIAL_OPERAND_LOADER_CAPTURE_EN
        ,
        .sum_bit     (sum_bit),
        .result      (result)
`endif
    );

`ifdef SERIAL_OPERAND_LOADER_CAPTURE_EN
    // Serial adder with registered sum, looped back to the loader.
    logic add_s = 1'b0;
    logic add_c = 1'b0;
    always @(posedge clk) begin
        if (adder_reset) begin
            add_s <= 1'b0;
            add_c <= 1'b0;
        end else begin
            add_s <= a_bit ^ b_bit ^ add_c;
            add_c <= (a_bit & b_bit) | (add_c & (a_bit ^ b_bit));
        end
    end
    assign sum_bit = add_s;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] r);
        frame_t f;
        f.a = a;
        f.b = b;
        f.r = r;
        exp_q.push_back(f);
        pushes++;
        $display("load a=%h b=%h expect_sum=%h at cycle %0d", a, b, r, cyc);
    endtask

    task automatic do_load(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] r);
        int i;
        for (i = 0; i < 20; i++) begin
            if (load_ready) break;
            tick();
        end
        if (i == 20) begin
            checks++;
            errors++;
            $display("FAIL load_ready_timeout at cycle %0d: got 0 expected 1", cyc);
        end else begin
            load_valid = 1'b1;
            op_a = a;
            op_b = b;
            push(a, b, r);
            tick();
            load_valid = 1'b0;
        end
    endtask

    // Monitor: protocol-level checking of every cycle against the queued frames.
    initial begin
        int     phase;
        int     idx;
        logic   expc;
        frame_t cur;
        logic [6:0] obs;
        phase = 0;
        idx = 0;
        expc = 1'b0;
        forever begin
            @(negedge clk);
            obs = {load_ready, adder_reset, bit_valid, a_bit, b_bit, last_bit, done};
            if (reset) begin
                chk("reset_outputs", {25'd0, obs}, 32'd0);
`ifdef SERIAL_OPERAND_LOADER_CAPTURE_EN
                chk("reset_result", {28'd0, result}, 32'd0);
`endif
                if (phase != 0) $display("frame abandoned by reset at cycle %0d", cyc);
                phase = 0;
                expc = 1'b0;
            end else if (expc) begin
                expc = 1'b0;
                chk("clear_cycle", {25'd0, obs}, 32'b0100000);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame at cycle %0d: got clear expected none", cyc);
                    cur.a = '0;
                    cur.b = '0;
                    cur.r = '0;
                end else begin
                    cur = exp_q.pop_front();
                end
                phase = 1;
                idx = 0;
            end else begin
                case (phase)
                    0: chk("idle_outputs", {25'd0, obs}, 32'b1000000);
                    1: begin
                        chk("shift_bit", {25'd0, obs},
                            {25'd0, 2'b00, 1'b1, cur.a[idx], cur.b[idx], (idx == W - 1), 1'b0});
                        idx++;
                        if (idx == W) phase = 2;
                    end
                    default: begin
                        chk("done_cycle", {25'd0, obs}, 32'b0000001);
`ifdef SERIAL_OPERAND_LOADER_CAPTURE_EN
                        chk("result", {28'd0, result}, {28'd0, cur.r});
`endif
                        $display("frame a=%h b=%h done at cycle %0d", cur.a, cur.b, cyc);
                        frames_done++;
                        phase = 0;
                    end
                endcase
            end
            if (!reset && load_valid && load_ready) expc = 1'b1;
        end
    end

    // Driver
    initial begin
        int last_hs;
        int k;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        do_load(4'b0101, 4'b0011, 4'b1000);
        repeat (W + 4) tick();

        for (int v = 1; v < 4; v++) begin
            do_load(tab_a[v], tab_b[v], tab_r[v]);
            repeat (W + 4) tick();
        end

        // Held-valid streaming with operands changing every cycle.
        last_hs = -1;
        load_valid = 1'b1;
        for (k = 0; k < 24; k++) begin
            op_a = tab_a[k % 8];
            op_b = tab_b[k % 8];
            if (load_ready) begin
                push(op_a, op_b, tab_r[k % 8]);
                if (last_hs >= 0) chk("hs_spacing", k - last_hs, W + 3);
                last_hs = k;
            end
            tick();
        end
        load_valid = 1'b0;
        repeat (W + 4) tick();

        // Reset in the second SHIFT cycle.
        do_load(4'hC, 4'h5, 4'h1);
        tick();
        tick();
        reset = 1'b1;
        aborted++;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        do_load(4'h3, 4'h4, 4'h7);
        repeat (W + 4) tick();

        // Reset coincident with load_valid.
        reset = 1'b1;
        load_valid = 1'b1;
        op_a = 4'h7;
        op_b = 4'h8;
        tick();
        reset = 1'b0;
        load_valid = 1'b0;
        repeat (4) tick();

        do_load(4'hE, 4'hE, 4'hC);
        repeat (W + 6) tick();

        chk("frames_completed", frames_done, pushes - aborted);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout at cycle %0d: got running expected finished", cyc);
        $fatal(1, "timeout");
    end
endmodule
